// File: rtl/ahb_mtx_dec_param.sv
// AHB matrix input-stage decoder: address-to-port decode, data-phase response mux,
// built-in default slave with two-cycle ERROR response and unmapped-access capture.
module ahb_mtx_dec_param #(
   parameter int unsigned NUM_PORTS = 4,
   parameter logic [22*NUM_PORTS-1:0] REGION_LO = {22'h1000c0, 22'h180100, 22'h100000, 22'h080000},
   parameter logic [22*NUM_PORTS-1:0] REGION_HI = {22'h1400bf, 22'h18027f, 22'h10003f, 22'h08003f},
   parameter int unsigned CNT_W = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      HREADYS,
   input  logic                      sel_dec,
   input  logic [21:0]               decode_addr_dec,
   input  logic [1:0]                trans_dec,
   input  logic [NUM_PORTS-1:0]      active_dec_in,
   input  logic [NUM_PORTS-1:0]      readyout_dec,
   input  logic [2*NUM_PORTS-1:0]    resp_dec,
   input  logic [32*NUM_PORTS-1:0]   rdata_dec,
   input  logic [32*NUM_PORTS-1:0]   ruser_dec,
   input  logic                      err_clr,
   output logic [NUM_PORTS-1:0]      sel_dec_out,
   output logic                      active_dec,
   output logic                      HREADYOUTS,
   output logic [1:0]                HRESPS,
   output logic [31:0]               HRDATAS,
   output logic [31:0]               HRUSERS,
   output logic [21:0]               err_addr,
   output logic [CNT_W-1:0]          err_cnt
);

   localparam int unsigned PW = $clog2(NUM_PORTS + 1);
   localparam logic [PW-1:0] DS_IDX = PW'(NUM_PORTS);

   generate
      if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_num_ports
         $error("ahb_mtx_dec_param: NUM_PORTS must be in 1..8");
      end
   endgenerate

   typedef enum logic [1:0] {
      DS_OKAY = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   logic [PW-1:0] addr_port;
   logic [PW-1:0] dp_port;
   logic          hit;
   logic          ds_event;
   ds_state_t     ds_state;
   logic          ds_ready;
   logic [1:0]    ds_resp;

   // Lowest-index window match; IDLE keeps the current data-phase slave selected.
   always_comb begin
      addr_port = DS_IDX;
      hit       = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!hit && (REGION_LO[22*k +: 22] <= decode_addr_dec) &&
             (decode_addr_dec <= REGION_HI[22*k +: 22])) begin
            addr_port = PW'(k);
            hit       = 1'b1;
         end
      end
      if ((trans_dec == 2'b00) && (dp_port != DS_IDX)) begin
         addr_port = dp_port;
      end
   end

   always_comb begin
      sel_dec_out = '0;
      active_dec  = 1'b1;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (addr_port == PW'(k)) begin
            sel_dec_out[k] = sel_dec;
            active_dec     = active_dec_in[k];
         end
      end
   end

   assign ds_event = (addr_port == DS_IDX) & sel_dec & HREADYS & trans_dec[1];

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_port <= DS_IDX;
      end else if (HREADYS) begin
         dp_port <= addr_port;
      end
   end

   // Data-phase response mux; default slave drives zero data.
   always_comb begin
      HREADYOUTS = ds_ready;
      HRESPS     = ds_resp;
      HRDATAS    = '0;
      HRUSERS    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (dp_port == PW'(k)) begin
            HREADYOUTS = readyout_dec[k];
            HRESPS     = resp_dec[2*k +: 2];
            HRDATAS    = rdata_dec[32*k +: 32];
            HRUSERS    = ruser_dec[32*k +: 32];
         end
      end
   end

   // Default slave: ERROR is a wait cycle followed by a ready cycle.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ds_state <= DS_OKAY;
         ds_ready <= 1'b1;
         ds_resp  <= 2'b00;
      end else begin
         case (ds_state)
            DS_OKAY: begin
               if (ds_event) begin
                  ds_state <= DS_ERR1;
                  ds_ready <= 1'b0;
                  ds_resp  <= 2'b01;
               end
            end
            DS_ERR1: begin
               ds_state <= DS_ERR2;
               ds_ready <= 1'b1;
               ds_resp  <= 2'b01;
            end
            DS_ERR2: begin
               if (ds_event) begin
                  ds_state <= DS_ERR1;
                  ds_ready <= 1'b0;
                  ds_resp  <= 2'b01;
               end else begin
                  ds_state <= DS_OKAY;
                  ds_ready <= 1'b1;
                  ds_resp  <= 2'b00;
               end
            end
            default: begin
               ds_state <= DS_OKAY;
               ds_ready <= 1'b1;
               ds_resp  <= 2'b00;
            end
         endcase
      end
   end

   // Unmapped-access capture; a coincident event wins over the clear.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_cnt  <= '0;
         err_addr <= '0;
      end else if (err_clr) begin
         err_cnt  <= ds_event ? CNT_W'(1) : '0;
         err_addr <= ds_event ? decode_addr_dec : '0;
      end else if (ds_event) begin
         err_addr <= decode_addr_dec;
         if (err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Scoreboard bench for ahb_mtx_dec_param: decode, boundaries, default slave, IDLE hold,
// error-counter saturation/clear and reset during an ERROR response.
module tb_ahb_mtx_dec_param;

   localparam int unsigned NP = 4;
   localparam int unsigned CW = 2;
   localparam int DS = 4;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
   localparam logic [21:0] LO [4] = '{22'h080000, 22'h100000, 22'h180100, 22'h1000c0};
   localparam logic [21:0] HI [4] = '{22'h08003f, 22'h10003f, 22'h18027f, 22'h1400bf};

   typedef struct packed {
      logic        rdy;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [31:0] ruser;
   } exp_t;

   logic              HCLK = 1'b0;
   logic              HRESET;
   logic              HREADYS;
   logic              sel_dec;
   logic [21:0]       decode_addr_dec;
   logic [1:0]        trans_dec;
   logic [NP-1:0]     active_dec_in;
   logic [NP-1:0]     readyout_dec;
   logic [2*NP-1:0]   resp_dec;
   logic [32*NP-1:0]  rdata_dec;
   logic [32*NP-1:0]  ruser_dec;
   logic              err_clr;
   logic [NP-1:0]     sel_dec_out;
   logic              active_dec;
   logic              HREADYOUTS;
   logic [1:0]        HRESPS;
   logic [31:0]       HRDATAS;
   logic [31:0]       HRUSERS;
   logic [21:0]       err_addr;
   logic [CW-1:0]     err_cnt;

   exp_t        sb[$];
   exp_t        obs;
   exp_t        e;
   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_cnt = 0;
   logic [21:0] exp_eaddr = '0;

   always #5 HCLK = ~HCLK;
   assign HREADYS = HREADYOUTS;
   assign obs = {HREADYOUTS, HRESPS, HRDATAS, HRUSERS};

   ahb_mtx_dec_param #(.NUM_PORTS(NP), .CNT_W(CW)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
      .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec),
      .active_dec_in(active_dec_in), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
      .rdata_dec(rdata_dec), .ruser_dec(ruser_dec), .err_clr(err_clr),
      .sel_dec_out(sel_dec_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
      .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS),
      .err_addr(err_addr), .err_cnt(err_cnt)
   );

   function automatic logic [31:0] rd_of(input int p);
      return 32'hD000_0000 + 32'(p) * 32'h0101_0101;
   endfunction

   function automatic logic [31:0] ru_of(input int p);
      return 32'hE100_0000 + 32'(p) * 32'h0010_0001;
   endfunction

   function automatic logic [21:0] a22(input logic [31:0] a);
      return a[31:10];
   endfunction

   function automatic int model_port(input logic [21:0] a);
      for (int k = 0; k < 4; k++) if (a >= LO[k] && a <= HI[k]) return k;
      return DS;
   endfunction

   function automatic logic [3:0] model_sel(input int p, input logic s);
      return (s && p < 4) ? (4'b0001 << p) : 4'b0000;
   endfunction

   function automatic logic model_act(input int p);
      logic [3:0] act;
      act = active_dec_in;
      return (p == DS) ? 1'b1 : act[p[1:0]];
   endfunction

   function automatic exp_t port_exp(input int p);
      exp_t x;
      x.rdy   = 1'b1;
      x.resp  = (p == DS) ? 2'b00 : 2'(p);
      x.rdata = (p == DS) ? 32'h0 : rd_of(p);
      x.ruser = (p == DS) ? 32'h0 : ru_of(p);
      return x;
   endfunction

   function automatic exp_t err_exp(input logic rdy);
      exp_t x;
      x.rdy = rdy; x.resp = 2'b01; x.rdata = '0; x.ruser = '0;
      return x;
   endfunction

   function automatic void bump_cnt(input logic clr);
      if (clr) exp_cnt = 1;
      else if (exp_cnt < 3) exp_cnt = exp_cnt + 1;
   endfunction

   task automatic drive(input logic [21:0] a, input logic [1:0] t, input logic s);
      @(posedge HCLK); #1;
      decode_addr_dec = a; trans_dec = t; sel_dec = s;
   endtask

   task automatic test_reset;
      HRESET = 1'b1; sel_dec = 1'b0; trans_dec = IDLE; decode_addr_dec = '0; err_clr = 1'b0;
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      e = port_exp(DS);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_out got=%h want=%h", obs, e); end
      n_cmp++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", err_cnt); end
      n_cmp++; if (err_addr !== 22'h0) begin n_err++; $display("FAIL reset_eaddr got=%h want=0", err_addr); end
      n_cmp++; if (sel_dec_out !== 4'b0000) begin n_err++; $display("FAIL reset_sel got=%b want=0000", sel_dec_out); end
      exp_cnt = 0; exp_eaddr = '0;
   endtask

   task automatic test_decode;
      drive(a22(32'h2000_0400), NONSEQ, 1'b1);
      @(negedge HCLK);
      n_cmp++; if (sel_dec_out !== 4'b0001) begin n_err++; $display("FAIL dec_p0_sel got=%b want=0001", sel_dec_out); end
      n_cmp++; if (active_dec !== model_act(0)) begin n_err++; $display("FAIL dec_p0_act got=%b want=%b", active_dec, model_act(0)); end
      sb.push_back(port_exp(0));
      drive(a22(32'h4003_1000), NONSEQ, 1'b1);
      @(negedge HCLK);
      n_cmp++; if (sel_dec_out !== 4'b1000) begin n_err++; $display("FAIL dec_p3_sel got=%b want=1000", sel_dec_out); end
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL dec_p0_data got=%h want=%h", obs, e); end
      sb.push_back(port_exp(3));
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL dec_p3_data got=%h want=%h", obs, e); end
      n_cmp++; if (sel_dec_out !== 4'b0000) begin n_err++; $display("FAIL dec_nosel got=%b want=0000", sel_dec_out); end
   endtask

   // BUSY sweep across window edges: DS answers zero-wait OKAY and never errors.
   task automatic test_boundary;
      logic [21:0] tbl [17] = '{22'h080000, 22'h07ffff, 22'h08003f, 22'h080040, 22'h100000,
                                22'h10003f, 22'h100040, 22'h1800ff, 22'h180100, 22'h18027f,
                                22'h180280, 22'h1000bf, 22'h1000c0, 22'h1400bf, 22'h1400c0,
                                22'h3fffff, 22'h000000};
      int p;
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i], BUSY, 1'b1);
         @(negedge HCLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL bound_data i=%0d got=%h want=%h", i, obs, e); end
         end
         p = model_port(tbl[i]);
         n_cmp++; if (sel_dec_out !== model_sel(p, 1'b1)) begin n_err++; $display("FAIL bound_sel a=%h got=%b want=%b", tbl[i], sel_dec_out, model_sel(p, 1'b1)); end
         n_cmp++; if (active_dec !== model_act(p)) begin n_err++; $display("FAIL bound_act a=%h got=%b want=%b", tbl[i], active_dec, model_act(p)); end
         sb.push_back(port_exp(p));
      end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL bound_last got=%h want=%h", obs, e); end
      n_cmp++; if (err_cnt !== 2'(exp_cnt)) begin n_err++; $display("FAIL bound_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_default_slave;
      drive(a22(32'h3000_0000), NONSEQ, 1'b1);
      @(negedge HCLK);
      n_cmp++; if (sel_dec_out !== 4'b0000) begin n_err++; $display("FAIL ds_sel got=%b want=0000", sel_dec_out); end
      n_cmp++; if (active_dec !== 1'b1) begin n_err++; $display("FAIL ds_act got=%b want=1", active_dec); end
      sb.push_back(err_exp(1'b0));
      sb.push_back(err_exp(1'b1));
      bump_cnt(1'b0); exp_eaddr = 22'h0c0000;
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ds_err1 got=%h want=%h", obs, e); end
      n_cmp++; if (err_addr !== exp_eaddr) begin n_err++; $display("FAIL ds_eaddr got=%h want=%h", err_addr, exp_eaddr); end
      n_cmp++; if (err_cnt !== 2'(exp_cnt)) begin n_err++; $display("FAIL ds_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ds_err2 got=%h want=%h", obs, e); end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = port_exp(DS);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ds_okay got=%h want=%h", obs, e); end
   endtask

   task automatic test_idle_hold;
      drive(22'h100010, NONSEQ, 1'b1);
      @(negedge HCLK);
      n_cmp++; if (sel_dec_out !== 4'b0010) begin n_err++; $display("FAIL hold_p1_sel got=%b want=0010", sel_dec_out); end
      sb.push_back(port_exp(1));
      drive(a22(32'h3000_0000), IDLE, 1'b1);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hold_p1_data got=%h want=%h", obs, e); end
      n_cmp++; if (sel_dec_out !== 4'b0010) begin n_err++; $display("FAIL hold_sel got=%b want=0010", sel_dec_out); end
      n_cmp++; if (active_dec !== model_act(1)) begin n_err++; $display("FAIL hold_act got=%b want=%b", active_dec, model_act(1)); end
      sb.push_back(port_exp(1));
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hold_idle_data got=%h want=%h", obs, e); end
      n_cmp++; if (err_cnt !== 2'(exp_cnt)) begin n_err++; $display("FAIL hold_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
      n_cmp++; if (err_addr !== exp_eaddr) begin n_err++; $display("FAIL hold_eaddr got=%h want=%h", err_addr, exp_eaddr); end
   endtask

   task automatic test_back_to_back;
      int k;
      logic [21:0] a;
      for (int i = 0; i < 24; i++) begin
         k = int'($urandom_range(0, 3));
         a = LO[k] + 22'($urandom_range(0, 32'(HI[k] - LO[k])));
         drive(a, ($urandom_range(0, 1) != 0) ? NONSEQ : SEQ, 1'b1);
         @(negedge HCLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, obs, e); end
         end
         n_cmp++; if (sel_dec_out !== model_sel(k, 1'b1)) begin n_err++; $display("FAIL b2b_sel a=%h got=%b want=%b", a, sel_dec_out, model_sel(k, 1'b1)); end
         sb.push_back(port_exp(k));
      end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL b2b_last got=%h want=%h", obs, e); end
   endtask

   // Clear alone, then back-to-back unmapped NONSEQs (issued in the ERR2 cycle) to saturate.
   task automatic test_saturation;
      logic [21:0] a;
      drive(22'h0, IDLE, 1'b0);
      err_clr = 1'b1;
      drive(22'h0, IDLE, 1'b0);
      err_clr = 1'b0;
      @(negedge HCLK);
      exp_cnt = 0; exp_eaddr = '0;
      n_cmp++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL clr_cnt got=%0d want=0", err_cnt); end
      n_cmp++; if (err_addr !== 22'h0) begin n_err++; $display("FAIL clr_eaddr got=%h want=0", err_addr); end
      for (int i = 0; i < 6; i++) begin
         a = 22'h0c0100 + 22'(i);
         drive(a, NONSEQ, 1'b1);
         err_clr = (i == 5);
         @(negedge HCLK);
         if (i > 0) begin
            e = sb.pop_front();
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sat_err2 i=%0d got=%h want=%h", i, obs, e); end
         end
         sb.push_back(err_exp(1'b0));
         sb.push_back(err_exp(1'b1));
         bump_cnt(i == 5); exp_eaddr = a;
         drive(22'h0, IDLE, 1'b0);
         err_clr = 1'b0;
         @(negedge HCLK);
         e = sb.pop_front();
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sat_err1 i=%0d got=%h want=%h", i, obs, e); end
         n_cmp++; if (err_cnt !== 2'(exp_cnt)) begin n_err++; $display("FAIL sat_cnt i=%0d got=%0d want=%0d", i, err_cnt, exp_cnt); end
         n_cmp++; if (err_addr !== exp_eaddr) begin n_err++; $display("FAIL sat_eaddr i=%0d got=%h want=%h", i, err_addr, exp_eaddr); end
      end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sat_last got=%h want=%h", obs, e); end
   endtask

   task automatic test_reset_mid_error;
      drive(22'h0c0200, NONSEQ, 1'b1);
      @(negedge HCLK);
      sb.push_back(err_exp(1'b0));
      drive(22'h0, IDLE, 1'b0);
      HRESET = 1'b1;
      @(negedge HCLK);
      e = sb.pop_front();
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rst_err1 got=%h want=%h", obs, e); end
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      exp_cnt = 0; exp_eaddr = '0;
      e = port_exp(DS);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rst_okay got=%h want=%h", obs, e); end
      n_cmp++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt got=%0d want=0", err_cnt); end
      n_cmp++; if (err_addr !== 22'h0) begin n_err++; $display("FAIL rst_eaddr got=%h want=0", err_addr); end
      drive(22'h0, IDLE, 1'b0);
      @(negedge HCLK);
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rst_no_err2 got=%h want=%h", obs, e); end
   endtask

   initial begin
      active_dec_in = 4'b0101;
      readyout_dec  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         resp_dec[2*k +: 2]   = 2'(k);
         rdata_dec[32*k +: 32] = rd_of(k);
         ruser_dec[32*k +: 32] = ru_of(k);
      end
      test_reset;
      test_decode;
      test_boundary;
      test_default_slave;
      test_idle_hold;
      test_back_to_back;
      test_saturation;
      test_reset_mid_error;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
